// File: rtl/vga_console_tty_engine_if.sv
// Byte-input and text-buffer port bundle for the VGA console TTY engine.
//   in_valid/in_ready/in_char/in_color : byte stream into the engine
//   wr_en/wr_addr/wr_char/wr_color     : buffer write port (engine drives)
//   rd_addr/rd_char/rd_color           : combinational buffer read port
// master = byte source plus text buffer; slave = the TTY engine.
interface vga_console_tty_engine_if #(
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_char;
   logic [2:0]        in_color;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [6:0]        wr_char;
   logic [2:0]        wr_color;
   logic [ADDR_W-1:0] rd_addr;
   logic [6:0]        rd_char;
   logic [2:0]        rd_color;

   modport master (
      output in_valid, in_char, in_color, rd_char, rd_color,
      input  in_ready, wr_en, wr_addr, wr_char, wr_color, rd_addr
   );

   modport slave (
      input  in_valid, in_char, in_color, rd_char, rd_color,
      output in_ready, wr_en, wr_addr, wr_char, wr_color, rd_addr
   );
endinterface

// File: rtl/vga_console_tty_engine.sv
// Character-stream front end for the VGA text console: turns a byte stream
// into text-buffer writes, tracking the cursor and handling CR/LF/BS/FF,
// scroll-up and full clear.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus (slave)     byte input, buffer write port, buffer read-back port
//   cur_row/cur_col cursor position
//   busy            FSM not idle or byte FIFO non-empty
// Build option: define TTY_AUTOWRAP_EN to wrap the cursor to the next row
// (scrolling on the last row) after a printable lands in the last column.
//
// state  | meaning
// IDLE   | pop one byte per cycle from the FIFO and decode it
// SCROLL | copy rows 1..N-1 up one row, then blank the last row
// CLEAR  | write blank/DEFAULT_COLOR to every cell
module vga_console_tty_engine #(
   parameter int         NUM_ROWS      = 3,
   parameter int         NUM_COLS      = 10,
   parameter int         FIFO_DEPTH    = 4,
   parameter logic [2:0] DEFAULT_COLOR = 3'b010,
   localparam int NUM_CHARS = NUM_ROWS * NUM_COLS,
   localparam int A_W       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
   localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   vga_console_tty_engine_if.slave bus,
   output logic [ROW_W-1:0]      cur_row,
   output logic [COL_W-1:0]      cur_col,
   output logic                  busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [A_W-1:0]   LAST_IDX = A_W'(NUM_CHARS - 1);
   localparam logic [A_W-1:0]   COPY_N   = A_W'(NUM_CHARS - NUM_COLS);
   localparam logic [A_W-1:0]   COLS_A   = A_W'(NUM_COLS);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
   localparam logic [6:0]       BLANK    = 7'h20;

   typedef enum logic [1:0] {ST_IDLE, ST_SCROLL, ST_CLEAR} state_t;

   state_t          state;
   logic [A_W-1:0]  idx;
   logic            wr_en;
   logic [A_W-1:0]  wr_addr;
   logic [6:0]      wr_char;
   logic [2:0]      wr_color;

   // FIFO with one extra pointer bit to tell full from empty
   logic [10:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]  wr_ptr;
   logic [PTR_W:0]  rd_ptr;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic [7:0]      head_char;
   logic [2:0]      head_color;
   logic [A_W-1:0]  cur_addr;
   logic            in_copy;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push       = bus.in_valid && !fifo_full;
   assign head_char  = fifo_mem[rd_ptr[PTR_W-1:0]][10:3];
   assign head_color = fifo_mem[rd_ptr[PTR_W-1:0]][2:0];
   assign cur_addr   = A_W'(cur_row) * COLS_A + A_W'(cur_col);
   assign in_copy    = (state == ST_SCROLL) && (idx < COPY_N);

   assign bus.in_ready = !fifo_full;
   assign bus.wr_en    = wr_en;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_char  = wr_char;
   assign bus.wr_color = wr_color;
   // scroll source is one row below the destination
   assign bus.rd_addr  = in_copy ? idx + COLS_A : '0;
   assign busy         = (state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.in_char, bus.in_color};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         idx      <= '0;
         cur_row  <= '0;
         cur_col  <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_char  <= BLANK;
         wr_color <= DEFAULT_COLOR;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (head_char >= 8'h20 && head_char <= 8'h7E) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= cur_addr;
                     wr_char  <= head_char[6:0];
                     wr_color <= head_color;
                     if (cur_col != LAST_COL) begin
                        cur_col <= cur_col + 1'b1;
                     end
`ifdef TTY_AUTOWRAP_EN
                     else begin
                        cur_col <= '0;
                        if (cur_row != LAST_ROW) begin
                           cur_row <= cur_row + 1'b1;
                        end else begin
                           state <= ST_SCROLL;
                           idx   <= '0;
                        end
                     end
`endif
                  end else begin
                     case (head_char)
                        8'h0A: begin
                           cur_col <= '0;
                           if (cur_row != LAST_ROW) begin
                              cur_row <= cur_row + 1'b1;
                           end else begin
                              state <= ST_SCROLL;
                              idx   <= '0;
                           end
                        end
                        8'h0D: cur_col <= '0;
                        8'h08: if (cur_col != '0) cur_col <= cur_col - 1'b1;
                        8'h0C: begin
                           state   <= ST_CLEAR;
                           idx     <= '0;
                           cur_row <= '0;
                           cur_col <= '0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_SCROLL: begin
               wr_en   <= 1'b1;
               wr_addr <= idx;
               if (in_copy) begin
                  wr_char  <= bus.rd_char;
                  wr_color <= bus.rd_color;
               end else begin
                  wr_char  <= BLANK;
                  wr_color <= DEFAULT_COLOR;
               end
               if (idx == LAST_IDX) begin
                  state   <= ST_IDLE;
                  idx     <= '0;
                  cur_row <= LAST_ROW;
                  cur_col <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_CLEAR: begin
               wr_en    <= 1'b1;
               wr_addr  <= idx;
               wr_char  <= BLANK;
               wr_color <= DEFAULT_COLOR;
               if (idx == LAST_IDX) begin
                  state <= ST_IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_console_tty_engine.sv
// Directed bench for vga_console_tty_engine: acts as byte source and as the
// text buffer, logs every buffer write and compares against hand values.
`timescale 1ns/1ps
module tb_vga_console_tty_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cur_row;
   logic [3:0] cur_col;
   logic       busy;

   vga_console_tty_engine_if #(.ADDR_W(5)) bus ();

   vga_console_tty_engine dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .cur_row (cur_row),
      .cur_col (cur_col),
      .busy    (busy)
   );

   always #8 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [4:0] addr;
      logic [6:0] ch;
      logic [2:0] col;
      int         cyc;
   } wr_t;
   wr_t wq[$];

   logic [6:0] buf_char [30];
   logic [2:0] buf_col  [30];

   assign bus.rd_char  = (bus.rd_addr < 5'd30) ? buf_char[bus.rd_addr] : 7'h00;
   assign bus.rd_color = (bus.rd_addr < 5'd30) ? buf_col[bus.rd_addr]  : 3'h0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wq.push_back('{bus.wr_addr, bus.wr_char, bus.wr_color, cyc});
         if (bus.wr_addr < 5'd30) begin
            buf_char[bus.wr_addr] = bus.wr_char;
            buf_col[bus.wr_addr]  = bus.wr_color;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] c, input logic [2:0] col, output bit stalled);
      int n = 0;
      stalled = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_char  = c;
      bus.in_color = col;
      while (!bus.in_ready && n < 200) begin
         stalled = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("push_timeout", 1, 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] c, input logic [2:0] col);
      bit s;
      push_byte(c, col, s);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || bus.wr_en) && n < budget);
      chk("idle_timeout", (n >= budget), 0);
   endtask

   task automatic check_cursor(input string tag, input int row, input int col);
      chk({tag, "_row"}, cur_row, row);
      chk({tag, "_col"}, cur_col, col);
   endtask

   // 30 consecutive blank writes at addr 0..29 starting at wq[base]
   task automatic check_clear(input string tag, input int base);
      int bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (base + i >= wq.size()) bad++;
         else if (wq[base+i].addr != 5'(i) || wq[base+i].ch != 7'h20 ||
                  wq[base+i].col != 3'b010) bad++;
      end
      chk({tag, "_content"}, bad, 0);
      if (wq.size() >= base + 30)
         chk({tag, "_span"}, wq[base+29].cyc - wq[base].cyc, 29);
   endtask

   typedef struct {
      logic [7:0] ch;
      logic [2:0] col;
      bit         wr;
      logic [4:0] addr;
      logic [6:0] exp_ch;
      logic [2:0] exp_col;
      logic [1:0] row;
      logic [3:0] ccol;
   } vec_t;
   vec_t vecs[14];

   logic [6:0] exp_c [30];
   logic [2:0] exp_k [30];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit s;
      int first_stall;
      int bad;

      vecs[0]  = '{8'h62, 3'd1, 1'b1, 5'd1,  7'h62, 3'd1, 2'd0, 4'd2};
      vecs[1]  = '{8'h80, 3'd3, 1'b0, 5'd0,  7'h00, 3'd0, 2'd0, 4'd2};
      vecs[2]  = '{8'h07, 3'd3, 1'b0, 5'd0,  7'h00, 3'd0, 2'd0, 4'd2};
      vecs[3]  = '{8'h08, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd0, 4'd1};
      vecs[4]  = '{8'h0D, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd0, 4'd0};
      vecs[5]  = '{8'h08, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd0, 4'd0};
      vecs[6]  = '{8'h0A, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd1, 4'd0};
      vecs[7]  = '{8'h78, 3'd7, 1'b1, 5'd10, 7'h78, 3'd7, 2'd1, 4'd1};
      vecs[8]  = '{8'h7E, 3'd0, 1'b1, 5'd11, 7'h7E, 3'd0, 2'd1, 4'd2};
      vecs[9]  = '{8'h1F, 3'd2, 1'b0, 5'd0,  7'h00, 3'd0, 2'd1, 4'd2};
      vecs[10] = '{8'h7F, 3'd2, 1'b0, 5'd0,  7'h00, 3'd0, 2'd1, 4'd2};
      vecs[11] = '{8'h0A, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd2, 4'd0};
      vecs[12] = '{8'h20, 3'd5, 1'b1, 5'd20, 7'h20, 3'd5, 2'd2, 4'd1};
      vecs[13] = '{8'h0D, 3'd0, 1'b0, 5'd0,  7'h00, 3'd0, 2'd2, 4'd0};

      for (int i = 0; i < 30; i++) begin
         buf_char[i] = 7'h00;
         buf_col[i]  = 3'h0;
      end
      bus.in_valid = 1'b0;
      bus.in_char  = 8'h00;
      bus.in_color = 3'h0;

      // reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_char", bus.wr_char, 7'h20);
      chk("rst_wr_color", bus.wr_color, 3'b010);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      check_cursor("rst", 0, 0);
      wq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 1);
      wait_idle(200);
      chk("rst_clear_count", wq.size(), 30);
      check_clear("rst_clear", 0);
      chk("rst_clear_busy", busy, 0);
      check_cursor("rst_clear", 0, 0);

      // first printable: latency and write
      wq.delete();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_char  = 8'h41;
      bus.in_color = 3'b100;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk("lat_after_push", bus.wr_en, 0);
      @(posedge clk);
      #1;
      chk("lat_after_pop", bus.wr_en, 1);
      chk("a_addr", bus.wr_addr, 0);
      chk("a_char", bus.wr_char, 7'h41);
      chk("a_color", bus.wr_color, 3'b100);
      wait_idle(20);
      chk("a_count", wq.size(), 1);
      check_cursor("a", 0, 1);

      // table: one byte each, compare write and cursor
      for (int v = 0; v < 14; v++) begin
         wq.delete();
         send(vecs[v].ch, vecs[v].col);
         wait_idle(100);
         chk($sformatf("v%0d_count", v), wq.size(), vecs[v].wr ? 1 : 0);
         if (vecs[v].wr && wq.size() == 1) begin
            chk($sformatf("v%0d_addr", v), wq[0].addr, vecs[v].addr);
            chk($sformatf("v%0d_char", v), wq[0].ch, vecs[v].exp_ch);
            chk($sformatf("v%0d_color", v), wq[0].col, vecs[v].exp_col);
         end
         check_cursor($sformatf("v%0d", v), vecs[v].row, vecs[v].ccol);
      end

      // form feed
      wq.delete();
      send(8'h0C, 3'd0);
      wait_idle(100);
      chk("ff_count", wq.size(), 30);
      check_clear("ff", 0);
      check_cursor("ff", 0, 0);

      // fill row 0
      wq.delete();
      for (int k = 0; k < 10; k++) send(8'h61 + 8'(k), 3'd1);
      wait_idle(100);
      chk("fill_count", wq.size(), 10);
      bad = 0;
      for (int k = 0; k < 10; k++)
         if (k >= wq.size() || wq[k].addr != 5'(k) || wq[k].ch != 7'h61 + 7'(k)) bad++;
      chk("fill_content", bad, 0);
`ifdef TTY_AUTOWRAP_EN
      check_cursor("fill", 1, 0);
`else
      check_cursor("fill", 0, 9);
`endif
      wq.delete();
      send(8'h5A, 3'd5);
      wait_idle(100);
      chk("z_count", wq.size(), 1);
      if (wq.size() == 1) begin
`ifdef TTY_AUTOWRAP_EN
         chk("z_addr", wq[0].addr, 10);
`else
         chk("z_addr", wq[0].addr, 9);
`endif
         chk("z_char", wq[0].ch, 7'h5A);
      end
`ifdef TTY_AUTOWRAP_EN
      check_cursor("z", 1, 1);
      send(8'h0D, 3'd0);
`else
      check_cursor("z", 0, 9);
      send(8'h0D, 3'd0);
      send(8'h0A, 3'd0);
`endif

      // row 1 = '0'..'8', row 2 = "xyz", then LF on last row
      for (int k = 0; k < 9; k++) send(8'h30 + 8'(k), 3'd6);
      send(8'h0A, 3'd0);
      send(8'h78, 3'd3);
      send(8'h79, 3'd3);
      send(8'h7A, 3'd3);
      wait_idle(100);
      check_cursor("pre_scroll", 2, 3);
      for (int i = 0; i < 30; i++) begin
         exp_c[i] = 7'h20;
         exp_k[i] = 3'b010;
      end
      for (int i = 0; i < 9; i++) begin
         exp_c[i] = 7'h30 + 7'(i);
         exp_k[i] = 3'd6;
      end
      for (int i = 0; i < 3; i++) begin
         exp_c[10+i] = 7'h78 + 7'(i);
         exp_k[10+i] = 3'd3;
      end
      wq.delete();
      send(8'h0A, 3'd0);
      wait_idle(200);
      chk("scroll_count", wq.size(), 30);
      bad = 0;
      for (int i = 0; i < 30; i++)
         if (i >= wq.size() || wq[i].addr != 5'(i) || wq[i].ch != exp_c[i] ||
             wq[i].col != exp_k[i]) bad++;
      chk("scroll_content", bad, 0);
      if (wq.size() >= 30) chk("scroll_span", wq[29].cyc - wq[0].cyc, 29);
      check_cursor("scroll", 2, 0);
      bad = 0;
      for (int i = 0; i < 9; i++)
         if (buf_char[i] != 7'h30 + 7'(i) || buf_col[i] != 3'd6) bad++;
      chk("scroll_row0_is_old_row1", bad, 0);

      // FIFO backpressure during CLEAR
      wq.delete();
      send(8'h0C, 3'd0);
      first_stall = -1;
      for (int k = 0; k < 8; k++) begin
         push_byte(8'h41 + 8'(k), 3'd7, s);
         if (s && first_stall < 0) first_stall = k;
      end
      chk("fifo_accepted_before_stall", first_stall, 4);
      wait_idle(200);
      chk("fifo_total_writes", wq.size(), 38);
      check_clear("fifo_clear", 0);
      bad = 0;
      for (int k = 0; k < 8; k++)
         if (30 + k >= wq.size() || wq[30+k].addr != 5'(k) ||
             wq[30+k].ch != 7'h41 + 7'(k) || wq[30+k].col != 3'd7) bad++;
      chk("fifo_bytes_in_order", bad, 0);
      check_cursor("fifo", 0, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
